gray_count_ctrl: RTL and testbench
==================================

Name: gray_count_ctrl

Overview:
- Command-driven sequencer for an N-bit gray-code counter.
- Accepts START/STOP/LOAD/CLEAR commands, latches a terminal limit, a direction and a one-shot/free-run mode, then steps the count one value per cycle.
- Holds the gray value in its own register, updated from the registered binary count, so gray_out changes exactly one bit per step, including wrap.
- Sits between a control master (CPU/test sequencer) and consumers of a gray timestamp or address.

Parameters:
- N, 8, counter width in bits (N >= 2).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  tied 1 (every command is accepted or flagged in one cycle)
- cmd_op  in  2  00 START, 01 STOP, 10 LOAD, 11 CLEAR
- cmd_data  in  N  binary load value (LOAD only)
- cfg_limit  in  N  binary terminal value, sampled on START
- cfg_down  in  1  1 = count down, sampled on START
- cfg_oneshot  in  1  1 = stop at limit, sampled on START
- bin_out  out  N  registered binary count
- gray_out  out  N  registered gray count, equal to bin_out ^ (bin_out >> 1)
- tc_pulse  out  1  one-cycle terminal-count pulse
- err_pulse  out  1  one-cycle illegal-command pulse
- busy  out  1  high while state == RUN

Behaviour:
- Reset (async, immediate, no clock needed):
  - state IDLE; bin_out, gray_out, latched limit, dir and mode = 0.
  - tc_pulse, err_pulse, busy = 0.
- States: IDLE, RUN, HOLD, DONE. A command is taken at the edge where cmd_valid=1.
- IDLE, HOLD and DONE:
  - LOAD: count := cmd_data, state unchanged.
  - CLEAR: count := 0, state unchanged.
  - START: latch cfg_*, go to RUN. No step on the accepting edge.
  - STOP: in IDLE/DONE, ignored with no error; in HOLD, also ignored with no error.
- RUN, evaluated each edge in this priority order:
  1. cmd STOP: go to HOLD. No step and no tc on that edge.
  2. cmd START/LOAD/CLEAR: err_pulse=1. Command dropped; stepping continues as below.
  3. count == latched limit:
     - tc_pulse=1.
     - One-shot: go to DONE and hold the count at limit.
     - Free-run: step.
  4. Otherwise: step. Up = +1 mod 2^N; down = -1 mod 2^N.
- Compare uses the current count, before the step.
- START when count already equals the limit: tc fires on the first RUN edge.
- Latency:
  - START accepted at edge k: busy=1 after edge k; first step at edge k+1.
  - Limit L reached from S going up (one-shot): tc_pulse is visible for the one cycle after edge k+(L-S)+1.
- Gray and binary registers always update on the same edge. Wrap FF->00 gives gray 0x80->0x00.
- tc_pulse and err_pulse are registered; each is high for exactly one cycle per event.
- Reset asserted mid-RUN: all outputs clear asynchronously. After deassertion the block waits in IDLE for a command.
- Latched config is unchanged by cfg_* inputs except on an accepted START (including START from HOLD).

Decomposition:
- Package gray_ctrl_pkg:
  - state enum (IDLE, RUN, HOLD, DONE).
  - op-code localparams OP_START, OP_STOP, OP_LOAD, OP_CLEAR.
  - bin2gray function.
- Sub-module gray_step_unit (combinational, parameter N):
  - Inputs: bin, down.
  - Outputs: next_bin, next_gray.
- Top contains the FSM, config latches and output registers.

Test Plan:
- Reset while RUN at count 0x37, asserted between edges -> bin_out=0, gray_out=0, busy=0 immediately; after release, no stepping without START.
- LOAD 0x05; START up, one-shot, limit 0x08:
  - bin 05,06,07,08 -> gray 07,05,04,0C.
  - tc_pulse for one cycle when compare hits 08; state DONE; count holds 0x08; busy=0.
- LOAD 0xFE; START up, free-run, limit 0x00:
  - bin FE,FF,00,01 -> gray 81,80,00,01.
  - tc_pulse exactly on the cycle after bin=00 is compared; single-bit gray change checked every step.
- LOAD 0x01; START down, free-run, limit 0xFF:
  - bin 01,00,FF -> gray 01,00,80.
  - tc fires at FF; counting continues to FE.
- During RUN issue LOAD 0x40 -> err_pulse=1, count keeps stepping. Then STOP -> HOLD with count frozen. Then LOAD 0x40 -> bin 0x40, gray 0x60. Then START -> resumes from 0x40.
- STOP on the edge where count == limit (one-shot) -> HOLD, no tc_pulse, count stays at limit. Next START -> tc on the first RUN edge, then DONE.

Source files
------------

// File: rtl/gray_ctrl_pkg.sv
// Shared types, command op-codes and the binary-to-gray helper for the gray counter sequencer.
package gray_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // Operates on a 32-bit container; callers truncate to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_step_unit.sv
// Combinational next-step value of the counter: +1 or -1 modulo 2^N, in binary and gray.
module gray_step_unit
    import gray_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] bin,
    input  logic         down,
    output logic [N-1:0] next_bin,
    output logic [N-1:0] next_gray
);

    always_comb begin
        next_bin  = down ? (bin - N'(1)) : (bin + N'(1));
        next_gray = N'(bin2gray(32'(next_bin)));
    end

endmodule

// File: rtl/gray_count_ctrl.sv
// Command-driven gray-code counter sequencer: FSM, latched run configuration and registered outputs.
//   state | meaning
//   IDLE  | after reset, waiting for a command; LOAD/CLEAR edit the count
//   RUN   | stepping one value per cycle toward the latched limit
//   HOLD  | paused by STOP; count frozen, START resumes with fresh config
//   DONE  | one-shot run reached its limit; count held at limit
module gray_count_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [N-1:0] cmd_data,
    input  logic [N-1:0] cfg_limit,
    input  logic         cfg_down,
    input  logic         cfg_oneshot,
    output logic [N-1:0] bin_out,
    output logic [N-1:0] gray_out,
    output logic         tc_pulse,
    output logic         err_pulse,
    output logic         busy
);

    state_t       state_q, state_d;
    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] gray_q, gray_d;
    logic [N-1:0] limit_q, limit_d;
    logic         down_q, down_d;
    logic         oneshot_q, oneshot_d;
    logic         tc_q, tc_d;
    logic         err_q, err_d;
    logic [N-1:0] step_bin;
    logic [N-1:0] step_gray;

    gray_step_unit #(.N(N)) u_step (
        .bin       (bin_q),
        .down      (down_q),
        .next_bin  (step_bin),
        .next_gray (step_gray)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            gray_q    <= '0;
            limit_q   <= '0;
            down_q    <= 1'b0;
            oneshot_q <= 1'b0;
            tc_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            gray_q    <= gray_d;
            limit_q   <= limit_d;
            down_q    <= down_d;
            oneshot_q <= oneshot_d;
            tc_q      <= tc_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        gray_d    = gray_q;
        limit_d   = limit_q;
        down_d    = down_q;
        oneshot_d = oneshot_q;
        tc_d      = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (cmd_valid && cmd_op == OP_STOP) begin
                    state_d = ST_HOLD;
                end else begin
                    // Any other command while running is rejected but does not stall the count.
                    err_d = cmd_valid;
                    tc_d  = (bin_q == limit_q);
                    if (tc_d && oneshot_q) begin
                        state_d = ST_DONE;
                    end else begin
                        bin_d  = step_bin;
                        gray_d = step_gray;
                    end
                end
            end
            default: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_START: begin
                            limit_d   = cfg_limit;
                            down_d    = cfg_down;
                            oneshot_d = cfg_oneshot;
                            state_d   = ST_RUN;
                        end
                        OP_LOAD: begin
                            bin_d  = cmd_data;
                            gray_d = N'(bin2gray(32'(cmd_data)));
                        end
                        OP_CLEAR: begin
                            bin_d  = '0;
                            gray_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    assign cmd_ready = 1'b1;
    assign bin_out   = bin_q;
    assign gray_out  = gray_q;
    assign tc_pulse  = tc_q;
    assign err_pulse = err_q;
    assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_gray_count_ctrl.sv
// Scoreboard bench for gray_count_ctrl: directed scenarios plus random commands against a behavioural model.
module tb_gray_count_ctrl;

    localparam int N   = 8;
    localparam int MOD = 1 << N;
    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_STOP  = 2'b01;
    localparam logic [1:0] C_LOAD  = 2'b10;
    localparam logic [1:0] C_CLEAR = 2'b11;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_DONE = 3;

    typedef struct {
        logic [N-1:0] bin;
        bit           tc;
        bit           err;
        bit           busy;
        bit           stepped;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [N-1:0] cmd_data = '0;
    logic [N-1:0] cfg_limit = '0;
    logic         cfg_down = 1'b0;
    logic         cfg_oneshot = 1'b0;
    logic [N-1:0] bin_out;
    logic [N-1:0] gray_out;
    logic         tc_pulse;
    logic         err_pulse;
    logic         busy;

    gray_count_ctrl #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cfg_limit   (cfg_limit),
        .cfg_down    (cfg_down),
        .cfg_oneshot (cfg_oneshot),
        .bin_out     (bin_out),
        .gray_out    (gray_out),
        .tc_pulse    (tc_pulse),
        .err_pulse   (err_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   passes = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [N-1:0] prev_gray = '0;

    int m_state = M_IDLE;
    int m_cnt = 0;
    int m_lim = 0;
    bit m_dn = 1'b0;
    bit m_os = 1'b0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_cnt   = 0;
        m_lim   = 0;
        m_dn    = 1'b0;
        m_os    = 1'b0;
    endtask

    task automatic model(input bit v, input logic [1:0] op, input int d, input int lim,
                         input bit dn, input bit os, output exp_t e);
        e.tc = 1'b0;
        e.err = 1'b0;
        e.stepped = 1'b0;
        if (m_state != M_RUN) begin
            if (v) begin
                if (op == C_START) begin
                    m_lim = lim & (MOD - 1);
                    m_dn = dn;
                    m_os = os;
                    m_state = M_RUN;
                end else if (op == C_LOAD) begin
                    m_cnt = d & (MOD - 1);
                end else if (op == C_CLEAR) begin
                    m_cnt = 0;
                end
            end
        end else if (v && op == C_STOP) begin
            m_state = M_HOLD;
        end else begin
            e.err = v;
            e.tc = (m_cnt == m_lim);
            if (e.tc && m_os) begin
                m_state = M_DONE;
            end else begin
                m_cnt = (m_cnt + (m_dn ? MOD - 1 : 1)) % MOD;
                e.stepped = 1'b1;
            end
        end
        e.bin  = m_cnt[N-1:0];
        e.busy = (m_state == M_RUN);
    endtask

    task automatic cyc(input bit v, input logic [1:0] op, input int d = 0, input int lim = 0,
                       input bit dn = 1'b0, input bit os = 1'b0);
        exp_t e;
        @(negedge clk);
        cmd_valid   = v;
        cmd_op      = op;
        cmd_data    = d[N-1:0];
        cfg_limit   = lim[N-1:0];
        cfg_down    = dn;
        cfg_oneshot = os;
        model(v, op, d, lim, dn, os, e);
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    // cmd_valid low; cfg inputs wiggle randomly and must not be picked up.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 2'($urandom), int'($urandom), int'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bin"}, bin_out, 0);
        check({tag, "_gray"}, gray_out, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tc"}, tc_pulse, 0);
        check({tag, "_err"}, err_pulse, 0);
        check({tag, "_ready"}, cmd_ready, 1);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("bin", bin_out, mon_e.bin);
            check("gray", gray_out, to_gray(mon_e.bin));
            check("tc", tc_pulse, mon_e.tc);
            check("err", err_pulse, mon_e.err);
            check("busy", busy, mon_e.busy);
            if (mon_e.stepped) check("gray_one_bit_step", $countones(gray_out ^ prev_gray), 1);
            prev_gray = gray_out;
        end
    end

    initial begin
        int r;
        int k;
        bit dn;
        bit v;
        int lim;

        #1 reset = 1'b1;
        #2 check_reset_outputs("por");
        @(negedge clk) reset = 1'b0;
        model_reset();

        // Reset asserted between edges while running at 0x37.
        cyc(1'b1, C_LOAD, 'h30);
        cyc(1'b1, C_START, 0, 'hA0, 1'b0, 1'b0);
        idle(7);
        #3 reset = 1'b1;
        #1 check_reset_outputs("mid_run_reset");
        model_reset();
        prev_gray = '0;
        @(negedge clk) reset = 1'b0;
        idle(4);

        // Up, one-shot, 05 -> 08.
        cyc(1'b1, C_LOAD, 'h05);
        cyc(1'b1, C_START, 0, 'h08, 1'b0, 1'b1);
        idle(6);

        // Up, free-run across wrap, limit 00.
        cyc(1'b1, C_LOAD, 'hFE);
        cyc(1'b1, C_START, 0, 'h00, 1'b0, 1'b0);
        idle(5);

        // Down, free-run across wrap, limit FF.
        cyc(1'b1, C_STOP);
        cyc(1'b1, C_LOAD, 'h01);
        cyc(1'b1, C_START, 0, 'hFF, 1'b1, 1'b0);
        idle(4);

        // Illegal command while running, then STOP / LOAD / resume.
        cyc(1'b1, C_LOAD, 'h40);
        idle(1);
        cyc(1'b1, C_STOP);
        idle(2);
        cyc(1'b1, C_LOAD, 'h40);
        cyc(1'b1, C_START, 0, 'hF0, 1'b0, 1'b1);
        idle(3);

        // STOP on the edge where count == limit, then restart at limit.
        cyc(1'b1, C_STOP);
        cyc(1'b1, C_LOAD, 'h10);
        cyc(1'b1, C_START, 0, 'h12, 1'b0, 1'b1);
        idle(2);
        cyc(1'b1, C_STOP);
        idle(1);
        cyc(1'b1, C_START, 0, 'h12, 1'b0, 1'b1);
        idle(3);

        // Random commands; limits placed near the current count so terminal counts occur.
        for (int i = 0; i < 600; i++) begin
            r   = $urandom_range(0, 9);
            v   = (r < 3);
            k   = $urandom_range(0, 6);
            dn  = 1'($urandom);
            lim = dn ? (m_cnt - k + MOD) % MOD : (m_cnt + k) % MOD;
            cyc(v, 2'($urandom), int'($urandom), lim, dn, 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
